// File: rtl/proc_control_fsm_pkg.sv
// Shared types and constants for the simple-processor control unit.
package proc_ctrl_pkg;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    OP_MV  = 4'b0000,
    OP_MVI = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011,
    OP_AND = 4'b0100,
    OP_OR  = 4'b0101,
    OP_XOR = 4'b0110
  } opcode_t;

  localparam logic [3:0] BUS_G    = 4'd8;
  localparam logic [3:0] BUS_DIN  = 4'd9;
  localparam logic [3:0] BUS_IDLE = 4'd15;

  localparam int unsigned OP_MSB = 9;
  localparam int unsigned OP_LSB = 6;
  localparam int unsigned RX_MSB = 5;
  localparam int unsigned RX_LSB = 3;
  localparam int unsigned RY_MSB = 2;
  localparam int unsigned RY_LSB = 0;

endpackage

// File: rtl/proc_control_fsm_dec3to8.sv
// Combinational 3-to-8 one-hot decoder with enable.
module dec3to8 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] y_c
);

  always_comb begin
    y_c = 8'd0;
    if (en) y_c[sel] = 1'b1;
  end

endmodule

// File: rtl/proc_control_fsm.sv
// Multi-cycle control unit: fetch on Run, then sequence T1-T3 per decoded opcode.
module proc_control_fsm
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned IW   = 10,
  parameter int unsigned NREG = 8
) (
  input  logic            CLKb,
  input  logic            RSTb,
  input  logic            Run,
  input  logic [IW-1:0]   IR,
  output logic            IR_E,
  output logic [NREG-1:0] Rin,
  output logic            A_E,
  output logic            G_E,
  output logic [2:0]      ALU_op,
  output logic [3:0]      Bus_sel,
  output logic            Busy,
  output logic            Done
);

  state_t     state, next_state;
  logic [3:0] opc;
  logic [2:0] rx, ry;
  logic       is_alu;
  logic       rin_en;
  logic [7:0] rin_c;

  assign opc    = IR[OP_MSB:OP_LSB];
  assign rx     = IR[RX_MSB:RX_LSB];
  assign ry     = IR[RY_MSB:RY_LSB];
  assign is_alu = (opc >= OP_ADD) && (opc <= OP_XOR);

  // State advances on the falling edge; reset returns to T0 immediately.
  always_ff @(negedge CLKb or negedge RSTb) begin
    if (!RSTb) state <= T0;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    IR_E       = 1'b0;
    A_E        = 1'b0;
    G_E        = 1'b0;
    rin_en     = 1'b0;
    ALU_op     = 3'd0;
    Bus_sel    = BUS_IDLE;
    Done       = 1'b0;
    Busy       = (state != T0);
    unique case (state)
      T0: begin
        // Run is masked during reset so no fetch can be requested.
        IR_E = Run & RSTb;
        if (Run) next_state = T1;
      end
      T1: begin
        next_state = T0;
        if (opc == OP_MV) begin
          Bus_sel = {1'b0, ry};
          rin_en  = 1'b1;
          Done    = 1'b1;
        end else if (opc == OP_MVI) begin
          Bus_sel = BUS_DIN;
          rin_en  = 1'b1;
          Done    = 1'b1;
        end else if (is_alu) begin
          Bus_sel    = {1'b0, rx};
          A_E        = 1'b1;
          next_state = T2;
        end else begin
          Done = 1'b1;
        end
      end
      T2: begin
        Bus_sel    = {1'b0, ry};
        G_E        = 1'b1;
        ALU_op     = is_alu ? opc[2:0] : 3'd0;
        next_state = T3;
      end
      T3: begin
        Bus_sel    = BUS_G;
        rin_en     = 1'b1;
        Done       = 1'b1;
        next_state = T0;
      end
      default: next_state = T0;
    endcase
  end

  dec3to8 u_dec (
    .en  (rin_en),
    .sel (rx),
    .y_c (rin_c)
  );

  assign Rin = NREG'(rin_c);

  a_rin_onehot: assert property (@(negedge CLKb) disable iff (!RSTb) $onehot0(Rin));
  a_one_enable: assert property (@(negedge CLKb) disable iff (!RSTb)
                                 $onehot0({IR_E, A_E, G_E, |Rin}));
  a_done_pulse: assert property (@(negedge CLKb) disable iff (!RSTb) Done |=> !Done);

endmodule

// File: tb/tb_proc_control_fsm.sv
// Directed bench for proc_control_fsm; outputs checked just after each falling edge.
module tb_proc_control_fsm;

  logic       CLKb = 1'b1;
  logic       RSTb;
  logic       Run;
  logic [9:0] IR;
  logic       IR_E, A_E, G_E, Busy, Done;
  logic [7:0] Rin;
  logic [2:0] ALU_op;
  logic [3:0] Bus_sel;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLKb = ~CLKb;

  proc_control_fsm #(.IW(10), .NREG(8)) dut (
    .CLKb    (CLKb),
    .RSTb    (RSTb),
    .Run     (Run),
    .IR      (IR),
    .IR_E    (IR_E),
    .Rin     (Rin),
    .A_E     (A_E),
    .G_E     (G_E),
    .ALU_op  (ALU_op),
    .Bus_sel (Bus_sel),
    .Busy    (Busy),
    .Done    (Done)
  );

  // Packed view: {IR_E, Rin, A_E, G_E, ALU_op, Bus_sel, Busy, Done}
  function automatic logic [19:0] ev(input logic ire, input logic [7:0] rin,
                                     input logic ae, input logic ge,
                                     input logic [2:0] op, input logic [3:0] bus,
                                     input logic busy, input logic done);
    return {ire, rin, ae, ge, op, bus, busy, done};
  endfunction

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [19:0] exp);
    check(tag, {IR_E, Rin, A_E, G_E, ALU_op, Bus_sel, Busy, Done}, exp);
  endtask

  task automatic next_fall();
    @(negedge CLKb);
    #1;
  endtask

  localparam logic [19:0] IDLE = 20'h0003C;  // Bus_sel=15, everything else 0
  localparam logic [19:0] FETCH = 20'h8003C; // IDLE plus IR_E

  initial begin
    RSTb = 1'b0;
    Run  = 1'b1;
    IR   = 10'd0;
    #2;
    chk_out("reset_gates_ire", IDLE);
    #5;
    RSTb = 1'b1;
    Run  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      next_fall();
      chk_out($sformatf("idle_%0d", i), IDLE);
    end

    // mv R2,R5
    IR = 10'b0000_010_101; Run = 1'b1; #1;
    chk_out("mv_t0", FETCH);
    next_fall(); Run = 1'b0; #1;
    chk_out("mv_t1", ev(0, 8'b0000_0100, 0, 0, 3'd0, 4'd5, 1, 1));
    next_fall();
    chk_out("mv_back_t0", IDLE);

    // add R1,R3 with Run dropped in T2
    IR = 10'b0010_001_011; Run = 1'b1; #1;
    chk_out("add_t0", FETCH);
    next_fall();
    chk_out("add_t1", ev(0, 8'd0, 1, 0, 3'd0, 4'd1, 1, 0));
    next_fall(); Run = 1'b0; #1;
    chk_out("add_t2", ev(0, 8'd0, 0, 1, 3'b010, 4'd3, 1, 0));
    next_fall();
    chk_out("add_t3", ev(0, 8'b0000_0010, 0, 0, 3'd0, 4'd8, 1, 1));
    next_fall();
    chk_out("add_back_t0", IDLE);

    // mvi R7 then undefined 1010, Run held high
    IR = 10'b0001_111_000; Run = 1'b1; #1;
    chk_out("mvi_t0", FETCH);
    next_fall();
    chk_out("mvi_t1", ev(0, 8'b1000_0000, 0, 0, 3'd0, 4'd9, 1, 1));
    next_fall();
    IR = 10'b1010_000_000; #1;
    chk_out("nop_t0_refetch", FETCH);
    next_fall();
    chk_out("nop_t1", ev(0, 8'd0, 0, 0, 3'd0, 4'd15, 1, 1));
    next_fall();
    chk_out("nop_back_t0", FETCH);
    Run = 1'b0; #1;
    chk_out("nop_idle", IDLE);

    // sub R4,R4, reset in T2
    IR = 10'b0011_100_100; Run = 1'b1; #1;
    chk_out("sub_t0", FETCH);
    next_fall();
    chk_out("sub_t1", ev(0, 8'd0, 1, 0, 3'd0, 4'd4, 1, 0));
    next_fall();
    chk_out("sub_t2", ev(0, 8'd0, 0, 1, 3'b011, 4'd4, 1, 0));
    #2; RSTb = 1'b0; #1;
    chk_out("sub_async_reset", IDLE);
    next_fall();
    chk_out("sub_reset_no_done", IDLE);
    RSTb = 1'b1; #1;
    chk_out("post_reset_t0", FETCH);
    next_fall(); Run = 1'b0; #1;
    chk_out("post_reset_t1", ev(0, 8'd0, 1, 0, 3'd0, 4'd4, 1, 0));
    next_fall();
    chk_out("post_reset_t2", ev(0, 8'd0, 0, 1, 3'b011, 4'd4, 1, 0));
    next_fall();
    chk_out("post_reset_t3", ev(0, 8'b0001_0000, 0, 0, 3'd0, 4'd8, 1, 1));
    next_fall();
    chk_out("post_reset_idle", IDLE);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
